fifo_flagged: RTL and testbench



---
 rtl/fifo_flagged.sv | 76 +++++++
 tb/tb_fifo_flagged.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fifo_flagged.sv
// fifo_flagged: parametrised synchronous FIFO with occupancy count, almost flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default is a registered read.
module fifo_flagged #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wren,
    input  logic                       rden,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       clr_err,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic                       o_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         wptr, rptr;
    logic                  wr_ok, rd_ok;

    // All status outputs decode from the registered pointers only.
    assign count        = wptr - rptr;
    assign empty        = count == '0;
    assign full         = count == DEPTH_C;
    assign almost_full  = count >= AF_C;
    assign almost_empty = count <= AE_C;
    assign rd_ok        = rden && !empty;
    assign wr_ok        = wren && (!full || rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + CW'(1);
            if (rd_ok) rptr <= rptr + CW'(1);
            overflow  <= (overflow && !clr_err) || (wren && !wr_ok);
            underflow <= (underflow && !clr_err) || (rden && !rd_ok);
        end
    end

`ifdef FIFO_FWFT_EN
    assign o_data  = mem[rptr[AW-1:0]];
    assign o_valid = !empty;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= rd_ok;
            if (rd_ok) o_data <= mem[rptr[AW-1:0]];
        end
    end
`endif
endmodule

// File: tb/tb_fifo_flagged.sv
// tb_fifo_flagged: vector table, corner sequences and random traffic against a queue model.
module tb_fifo_flagged;
    localparam int DEPTH = 8;
    localparam int AF = 6;
    localparam int AE = 2;
    localparam int NV = 21;

    logic       clk = 1'b0;
    logic       rst = 1'b1, wren = 1'b0, rden = 1'b0, clr_err = 1'b0;
    logic [7:0] i_data = '0, o_data;
    logic       o_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;
    int         checks = 0, failures = 0;

    logic [7:0] q[$];
    bit         m_ov, m_un, m_v;
    logic [7:0] m_d;

    typedef struct {
        bit rst, wr, rd, clr;
        logic [7:0] din;
        int c;
        bit f, e, af, ae, ov, un, v;
        logic [7:0] d;
    } vec_t;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    fifo_flagged #(.DEPTH(DEPTH), .DATA_WIDTH(8), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .rst(rst), .wren(wren), .rden(rden), .i_data(i_data), .clr_err(clr_err),
        .o_data(o_data), .o_valid(o_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of words plus sticky flags, updated from the accept rules.
    task automatic model(input bit r, input bit w, input bit rd, input bit c, input logic [7:0] din);
        bit rok, wok;
        logic [7:0] head;
        if (r) begin
            q.delete();
            m_ov = 0; m_un = 0; m_v = 0; m_d = '0;
        end else begin
            rok = rd && q.size() > 0;
            wok = w && (q.size() < DEPTH || rok);
            m_v = rok;
            if (rok) begin
                head = q.pop_front();
                m_d = head;
            end
            if (wok) q.push_back(din);
            m_ov = (m_ov && !c) || (w && !wok);
            m_un = (m_un && !c) || (rd && !rok);
        end
    endtask

    task automatic check_model();
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
`ifdef FIFO_FWFT_EN
        chk("o_valid", 32'(o_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("o_data", 32'(o_data), 32'(q[0]));
`else
        chk("o_valid", 32'(o_valid), 32'(m_v));
        chk("o_data", 32'(o_data), 32'(m_d));
`endif
    endtask

    task automatic step(input bit r, input bit w, input bit rd, input bit c, input logic [7:0] din);
        @(negedge clk);
        rst = r; wren = w; rden = rd; clr_err = c; i_data = din;
        @(posedge clk);
        model(r, w, rd, c, din);
        #1;
        check_model();
    endtask

    initial begin
        tbl[0]  = '{1,0,0,0,8'h00, 0, 0,1,0,1,0,0, 0,8'h00};
        tbl[1]  = '{0,1,0,0,8'h11, 1, 0,0,0,1,0,0, 0,8'h00};
        tbl[2]  = '{0,1,0,0,8'h12, 2, 0,0,0,1,0,0, 0,8'h00};
        tbl[3]  = '{0,1,0,0,8'h13, 3, 0,0,0,0,0,0, 0,8'h00};
        tbl[4]  = '{0,1,0,0,8'h14, 4, 0,0,0,0,0,0, 0,8'h00};
        tbl[5]  = '{0,1,0,0,8'h15, 5, 0,0,0,0,0,0, 0,8'h00};
        tbl[6]  = '{0,1,0,0,8'h16, 6, 0,0,1,0,0,0, 0,8'h00};
        tbl[7]  = '{0,1,0,0,8'h17, 7, 0,0,1,0,0,0, 0,8'h00};
        tbl[8]  = '{0,1,0,0,8'h18, 8, 1,0,1,0,0,0, 0,8'h00};
        tbl[9]  = '{0,1,0,0,8'h19, 8, 1,0,1,0,1,0, 0,8'h00};
        tbl[10] = '{0,0,1,0,8'h00, 7, 0,0,1,0,1,0, 1,8'h11};
        tbl[11] = '{0,0,1,0,8'h00, 6, 0,0,1,0,1,0, 1,8'h12};
        tbl[12] = '{0,0,1,0,8'h00, 5, 0,0,0,0,1,0, 1,8'h13};
        tbl[13] = '{0,0,1,0,8'h00, 4, 0,0,0,0,1,0, 1,8'h14};
        tbl[14] = '{0,0,1,0,8'h00, 3, 0,0,0,0,1,0, 1,8'h15};
        tbl[15] = '{0,0,1,0,8'h00, 2, 0,0,0,1,1,0, 1,8'h16};
        tbl[16] = '{0,0,1,0,8'h00, 1, 0,0,0,1,1,0, 1,8'h17};
        tbl[17] = '{0,0,1,0,8'h00, 0, 0,1,0,1,1,0, 1,8'h18};
        tbl[18] = '{0,0,1,0,8'h00, 0, 0,1,0,1,1,1, 0,8'h18};
        tbl[19] = '{0,0,0,1,8'h00, 0, 0,1,0,1,0,0, 0,8'h18};
        tbl[20] = '{0,1,1,0,8'h21, 1, 0,0,0,1,0,1, 0,8'h18};

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].c));
            chk($sformatf("vec%0d.flags", i),
                {26'd0, full, empty, almost_full, almost_empty, overflow, underflow},
                {26'd0, tbl[i].f, tbl[i].e, tbl[i].af, tbl[i].ae, tbl[i].ov, tbl[i].un});
`ifndef FIFO_FWFT_EN
            chk($sformatf("vec%0d.valid", i), 32'(o_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d.data", i), 32'(o_data), 32'(tbl[i].d));
`endif
        end

        // Sustained write+read at occupancy 3, wrapping the pointers.
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'(8'h40 + i));
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 0, 8'(8'h50 + i));
            chk("stream_count", 32'(count), 32'd3);
        end

        // Full FIFO accepts a simultaneous write and read.
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 8'(8'h60 + i));
        step(0, 1, 1, 0, 8'h77);
        chk("full_simul_ovf", 32'(overflow), 32'd0);
        chk("full_simul_count", 32'(count), 32'd8);

        // Reset at count 5 discards contents; next write/read returns the new word.
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'(8'h80 + i));
        step(1, 0, 0, 0, 8'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_status", {27'd0, empty, full, o_valid, overflow, underflow}, 32'b10000);
        step(0, 1, 0, 0, 8'hA5);
`ifdef FIFO_FWFT_EN
        chk("fwft_valid", 32'(o_valid), 32'd1);
        chk("fwft_data", 32'(o_data), 32'hA5);
        step(0, 0, 1, 0, 8'h00);
        chk("fwft_pop_empty", 32'(empty), 32'd1);
        step(0, 1, 0, 0, 8'h3C);
        chk("fwft_3c_valid", 32'(o_valid), 32'd1);
        chk("fwft_3c_data", 32'(o_data), 32'h3C);
        step(0, 0, 1, 0, 8'h00);
        chk("fwft_3c_empty", 32'(empty), 32'd1);
`else
        step(0, 0, 1, 0, 8'h00);
        chk("post_rst_data", 32'(o_data), 32'hA5);
        chk("post_rst_valid", 32'(o_valid), 32'd1);
`endif

        // Random traffic alternating between fill-biased and drain-biased phases.
        for (int i = 0; i < 800; i++) begin
            int bias;
            bias = ((i / 40) % 2) ? 80 : 30;
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < bias,
                 $urandom_range(0, 99) < 110 - bias,
                 $urandom_range(0, 19) == 0,
                 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
